// File: rtl/imem_pkg.sv
// Shared constants for the instruction-memory loader: FSM encoding and
// the byte framing of the download stream (header length, word size).
package imem_pkg;

    // Header carries the 16-bit big-endian word count.
    localparam int HDR_BYTES      = 2;
    localparam int N_W            = HDR_BYTES * 8;

    // Program words are 32 bits, sent MSB byte first.
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = BYTES_PER_WORD * 8;
    localparam int CNT_W          = $clog2(BYTES_PER_WORD);

    // Loader FSM encoding.
    localparam logic [2:0] ST_HDR0 = 3'd0;
    localparam logic [2:0] ST_HDR1 = 3'd1;
    localparam logic [2:0] ST_LOAD = 3'd2;
    localparam logic [2:0] ST_RUN  = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

endpackage

// File: rtl/byte_packer.sv
// Byte-to-word assembler: shifts bytes in MSB first and raises a one-cycle
// word_ready strobe in the cycle after the last byte of a word arrives.
module byte_packer
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              last_byte,
    output logic              word_ready,
    output logic [WORD_W-1:0] word
);

    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic              ready_q, ready_d;

    // Combinational so the parent can decide its next state on the same
    // edge that completes the word.
    assign last_byte  = in_valid && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
    assign word_ready = ready_q;
    assign word       = shift_q;

    // Next-state: shift/count on each accepted byte, clear drops a partial word.
    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        ready_d = last_byte;
        if (clr) begin
            cnt_d = '0;
        end else if (in_valid) begin
            shift_d = {shift_q[WORD_W-9:0], in_data};
            cnt_d   = cnt_q + 1'b1;
        end
    end

    // Assembler state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            shift_q <= '0;
            ready_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            ready_q <= ready_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Serial program loader: parses a word-count header, writes the following
// words into instruction memory, then releases the processor and hands the
// memory address bus over to it.
module imem_loader
    import imem_pkg::*;
#(
    parameter int MEM_SIZE = 1201,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              reload,
    input  logic [ADDR_W-1:0] cpu_a,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_we,
    output logic [31:0]       mem_wd,
    output logic              cpu_run,
    output logic              load_err
);

    logic [2:0]        state_q, state_d;
    logic [N_W-1:0]    n_q,     n_d;
    logic [ADDR_W-1:0] idx_q,   idx_d;

    logic              pk_valid;
    logic              pk_last;
    logic              pk_ready;
    logic [WORD_W-1:0] pk_word;
    logic [N_W-1:0]    n_full;
    logic              last_word;

    // Reload takes priority over a coincident byte, so it never reaches the packer.
    assign pk_valid  = rx_valid && !reload && (state_q == ST_LOAD);
    assign n_full    = {n_q[N_W-1:8], rx_data};
    assign last_word = (32'(idx_q) + 32'd1) == 32'(n_q);

    byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (reload),
        .in_valid   (pk_valid),
        .in_data    (rx_data),
        .last_byte  (pk_last),
        .word_ready (pk_ready),
        .word       (pk_word)
    );

    // Next-state: header parse, load progress and reload handling.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        // A write in flight always retires its index, even alongside reload
        // (reload then overrides the index below).
        if (pk_ready) idx_d = idx_q + 1'b1;
        if (reload) begin
            state_d = ST_HDR0;
            n_d     = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_HDR0: if (rx_valid) begin
                    n_d     = {rx_data, {(N_W-8){1'b0}}};
                    state_d = ST_HDR1;
                end
                ST_HDR1: if (rx_valid) begin
                    n_d = n_full;
                    if (32'(n_full) > MEM_SIZE) state_d = ST_ERR;
                    else if (n_full == '0)      state_d = ST_RUN;
                    else                        state_d = ST_LOAD;
                end
                // Enter RUN on the edge that launches the final write, so the
                // processor is released in the same cycle as that write.
                ST_LOAD: if (pk_last && last_word) state_d = ST_RUN;
                ST_RUN:  ;
                ST_ERR:  ;
                default: state_d = ST_HDR0;
            endcase
        end
    end

    // Loader state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HDR0;
            n_q     <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
        end
    end

    assign mem_we   = pk_ready;
    assign mem_wd   = pk_word;
    assign cpu_run  = (state_q == ST_RUN);
    assign load_err = (state_q == ST_ERR);
    // The final write lands while already in RUN; it keeps the bus for that cycle.
    assign mem_a    = (cpu_run && !pk_ready) ? cpu_a : idx_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: queue-based reference model compared
// every cycle, plus literal expectations for the documented scenarios.
module tb_imem_loader;

    localparam int MEM_SIZE = 1201;
    localparam int ADDR_W   = 16;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic [7:0]        rx_data  = '0;
    logic              rx_valid = 1'b0;
    logic              reload   = 1'b0;
    logic [ADDR_W-1:0] cpu_a    = '0;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_we;
    logic [31:0]       mem_wd;
    logic              cpu_run;
    logic              load_err;

    int checks = 0;
    int errors = 0;

    imem_loader #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .reload   (reload),
        .cpu_a    (cpu_a),
        .mem_a    (mem_a),
        .mem_we   (mem_we),
        .mem_wd   (mem_wd),
        .cpu_run  (cpu_run),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0]  hdr[$];
    logic [7:0]  dq[$];
    int          n_words;
    int          words;      // writes completed since last reload
    bit          m_err, m_run, m_pend;
    logic [31:0] m_pdata;

    typedef struct {
        int          a;
        logic [31:0] d;
        bit          run;
    } wr_t;
    wr_t wlog[$];

    task automatic model_clear();
        hdr.delete();
        dq.delete();
        n_words = 0;
        words   = 0;
        m_err   = 0;
        m_run   = 0;
    endtask

    task automatic model_reset();
        model_clear();
        m_pend  = 0;
        m_pdata = '0;
    endtask

    task automatic model_edge();
        if (m_pend) words++;
        m_pend = 0;
        if (reload) begin
            model_clear();
        end else if (rx_valid && !m_run && !m_err) begin
            if (hdr.size() < 2) begin
                hdr.push_back(rx_data);
                if (hdr.size() == 2) begin
                    n_words = int'({hdr[0], hdr[1]});
                    if (n_words > MEM_SIZE) m_err = 1;
                    else if (n_words == 0)  m_run = 1;
                end
            end else begin
                dq.push_back(rx_data);
                if (dq.size() == 4) begin
                    m_pend  = 1;
                    m_pdata = {dq[0], dq[1], dq[2], dq[3]};
                    dq.delete();
                    if (words + 1 == n_words) m_run = 1;
                end
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_edge();
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [ADDR_W-1:0] ea;
        ea = (m_run && !m_pend) ? cpu_a : ADDR_W'(words);
        chk("mem_we",   32'(mem_we),   32'(m_pend));
        chk("cpu_run",  32'(cpu_run),  32'(m_run));
        chk("load_err", 32'(load_err), 32'(m_err));
        chk("mem_a",    32'(mem_a),    32'(ea));
        if (m_pend) chk("mem_wd", mem_wd, m_pdata);
        if (rst_n && mem_we) wlog.push_back('{int'(mem_a), mem_wd, cpu_run});
    endtask

    always @(negedge clk) compare_all();

    // ---------------- stimulus ----------------
    task automatic step(input bit v, input logic [7:0] d, input bit rl);
        rx_valid = v;
        rx_data  = d;
        reload   = rl;
        cpu_a    = ADDR_W'($urandom);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        reload   = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int max_gap);
        step(1'b1, b, 1'b0);
        repeat ($urandom_range(0, max_gap)) step(1'b0, 8'($urandom), 1'b0);
    endtask

    task automatic send_hdr(input logic [15:0] n, input int g);
        send(n[15:8], g);
        send(n[7:0], g);
    endtask

    task automatic send_word(input logic [31:0] w, input int g);
        send(w[31:24], g);
        send(w[23:16], g);
        send(w[15:8], g);
        send(w[7:0], g);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_wd", mem_wd, 0);
        chk("rst_mem_a", 32'(mem_a), 0);
        chk("rst_cpu_run", 32'(cpu_run), 0);
        chk("rst_load_err", 32'(load_err), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b0);

        // Two-word program, back-to-back bytes
        wlog.delete();
        send_hdr(16'h0002, 0);
        send_word(32'h11223344, 0);
        send_word(32'hAABBCCDD, 0);
        step(1'b0, 8'h00, 1'b0);
        chk("two_count", 32'(wlog.size()), 2);
        if (wlog.size() == 2) begin
            chk("two_a0", 32'(wlog[0].a), 0);
            chk("two_d0", wlog[0].d, 32'h11223344);
            chk("two_run0", 32'(wlog[0].run), 0);
            chk("two_a1", 32'(wlog[1].a), 1);
            chk("two_d1", wlog[1].d, 32'hAABBCCDD);
            chk("two_run1", 32'(wlog[1].run), 1);
        end

        // Reload colliding with a byte while running
        step(1'b1, 8'h55, 1'b1);
        chk("rl_run_cpu_run", 32'(cpu_run), 0);
        chk("rl_run_mem_a", 32'(mem_a), 0);

        // Empty program: straight to RUN, address pass-through
        wlog.delete();
        send_hdr(16'h0000, 0);
        cpu_a = 16'h0123;
        #1;
        chk("empty_mem_a", 32'(mem_a), 32'h0123);
        chk("empty_cpu_run", 32'(cpu_run), 1);
        step(1'b0, 8'h00, 1'b0);
        chk("empty_no_write", 32'(wlog.size()), 0);

        // Oversized program -> ERR, data ignored, reload recovers
        step(1'b0, 8'h00, 1'b1);
        send_hdr(16'h04B2, 1);
        chk("err_load_err", 32'(load_err), 1);
        chk("err_cpu_run", 32'(cpu_run), 0);
        repeat (8) send(8'($urandom), 1);
        chk("err_no_write", 32'(wlog.size()), 0);
        chk("err_sticky", 32'(load_err), 1);
        step(1'b0, 8'h00, 1'b1);
        chk("err_cleared", 32'(load_err), 0);

        // Exactly MEM_SIZE words, back-to-back
        wlog.delete();
        send_hdr(16'(MEM_SIZE), 0);
        for (int i = 0; i < MEM_SIZE; i++) send_word($urandom, 0);
        step(1'b0, 8'h00, 1'b0);
        chk("full_count", 32'(wlog.size()), 32'(MEM_SIZE));
        if (wlog.size() == MEM_SIZE) chk("full_last_a", 32'(wlog[MEM_SIZE-1].a), 32'(MEM_SIZE - 1));
        chk("full_run", 32'(cpu_run), 1);

        // Reload after a partial word, then a fresh one-word program
        step(1'b0, 8'h00, 1'b1);
        wlog.delete();
        send_hdr(16'h0001, 1);
        send(8'hDE, 1);
        send(8'hAD, 1);
        step(1'b0, 8'h00, 1'b1);
        send_hdr(16'h0001, 1);
        send_word(32'hDEADBEEF, 1);
        step(1'b0, 8'h00, 1'b0);
        chk("partial_count", 32'(wlog.size()), 1);
        if (wlog.size() == 1) begin
            chk("partial_a", 32'(wlog[0].a), 0);
            chk("partial_d", wlog[0].d, 32'hDEADBEEF);
        end

        // Async reset mid-word
        step(1'b0, 8'h00, 1'b1);
        send_hdr(16'h0002, 0);
        send_word(32'h11223344, 0);
        send(8'hAA, 0);
        send(8'hBB, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_mem_we", 32'(mem_we), 0);
        chk("async_mem_wd", mem_wd, 0);
        chk("async_mem_a", 32'(mem_a), 0);
        chk("async_cpu_run", 32'(cpu_run), 0);
        chk("async_load_err", 32'(load_err), 0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        wlog.delete();
        send_hdr(16'h0002, 1);
        send_word(32'hCAFEF00D, 1);
        send_word(32'h01020304, 1);
        step(1'b0, 8'h00, 1'b0);
        chk("post_rst_count", 32'(wlog.size()), 2);
        if (wlog.size() == 2) chk("post_rst_d1", wlog[1].d, 32'h01020304);

        // Randomized programs, with random aborts and junk after the load
        for (int it = 0; it < 60; it++) begin
            logic [15:0] n;
            logic [7:0]  b;
            int          tot;
            int          ab_at;
            step(1'b0, 8'h00, 1'b1);
            case ($urandom_range(0, 9))
                0:       n = 16'hFFFF;
                1:       n = 16'(MEM_SIZE + 1);
                2:       n = 16'h0000;
                default: n = 16'($urandom_range(1, 6));
            endcase
            tot   = 2 + ((int'(n) <= MEM_SIZE) ? 4 * int'(n) : 8);
            ab_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, tot - 1)) : -1;
            for (int i = 0; i < tot; i++) begin
                b = (i == 0) ? n[15:8] : (i == 1) ? n[7:0] : 8'($urandom);
                if (i == ab_at) begin
                    step(1'b1, b, 1'b1);
                    break;
                end
                send(b, 2);
            end
            repeat (4) step(1'($urandom), 8'($urandom), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
